microcode_sequencer: RTL and testbench

- Parametrised successor to the existing microcode fetch unit.
- Drives the address of an external combinational uop store (`uop = store[uop_addr]`) and decodes sequencing ops: jump, conditional branch, call/return with a hardware stack, counted loop, end.
- Issues datapath uops downstream over a valid/ready handshake. Started by a `start` pulse with an entry address.
- Sits between the uop store and the execution datapath.

---
 rtl/mcseq_pkg.sv | 22 ++
 rtl/mcseq_stack.sv | 39 +++
 rtl/microcode_sequencer.sv | 128 ++++++++++++
 tb/tb_microcode_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mcseq_pkg.sv
// mcseq_pkg: shared op/state encodings and field helpers for the microcode sequencer.
package mcseq_pkg;
    localparam int OP_W = 4;
    typedef enum logic [OP_W-1:0] {
        OP_NEXT  = 4'd0,
        OP_JMP   = 4'd1,
        OP_BRC   = 4'd2,
        OP_CALL  = 4'd3,
        OP_RET   = 4'd4,
        OP_LDCNT = 4'd5,
        OP_LOOP  = 4'd6,
        OP_END   = 4'd7
    } op_e;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_e;
    function automatic logic is_ext_op(input logic [OP_W-1:0] op);
        return op[OP_W-1];
    endfunction
endpackage

// File: rtl/mcseq_stack.sv
// mcseq_stack: DEPTH x W return-address LIFO; sp counts valid entries, top is the newest.
module mcseq_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);
    localparam int SPW = $clog2(DEPTH + 1);
    localparam int IW  = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [SPW-1:0] sp;
    logic [SPW-1:0] sp_m1;
    logic [W-1:0]   mem [DEPTH];
    assign sp_m1 = sp - 1'b1;
    assign full  = sp == SPW'(DEPTH);
    assign empty = sp == '0;
    assign top   = mem[sp_m1[IW-1:0]];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            sp <= '0;
        else if (clr)
            sp <= '0;
        else if (push && !full)
            sp <= sp + 1'b1;
        else if (pop && !empty)
            sp <= sp_m1;
    end
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[sp[IW-1:0]] <= din;
    end
endmodule

// File: rtl/microcode_sequencer.sv
// microcode_sequencer: fetches uops by PC, executes sequencing ops, issues datapath uops.
// Define MCSEQ_ILLEGAL_TRAP_EN to trap ops 8..15 into FAULT instead of issuing them.
module microcode_sequencer
    import mcseq_pkg::*;
#(
    parameter int UOP_BUF_SIZE  = 128,
    parameter int UOP_BUF_WIDTH = 32,
    parameter int STACK_DEPTH   = 4,
    parameter int NUM_COND      = 8,
    parameter int CNT_W         = 8,
    localparam int ADDR_W       = $clog2(UOP_BUF_SIZE),
    localparam int SEL_W        = $clog2(NUM_COND)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        entry_addr,
    output logic [ADDR_W-1:0]        uop_addr,
    input  logic [UOP_BUF_WIDTH-1:0] uop,
    input  logic [NUM_COND-1:0]      cond,
    output logic [UOP_BUF_WIDTH-1:0] uop_out,
    output logic                     uop_valid,
    input  logic                     uop_ready,
    output logic                     busy,
    output logic                     fault
);
    state_e              state, state_n;
    logic [ADDR_W-1:0]   pc, pc_n, pc_inc, target, top;
    logic [CNT_W-1:0]    cnt, cnt_n, imm;
    logic [SEL_W-1:0]    sel;
    op_e                 op;
    logic                push, pop, clr, issue, full, empty;
    assign op        = op_e'(uop[UOP_BUF_WIDTH-1 -: OP_W]);
    assign sel       = uop[UOP_BUF_WIDTH-OP_W-1 -: SEL_W];
    assign target    = uop[ADDR_W-1:0];
    assign imm       = uop[CNT_W-1:0];
    assign pc_inc    = pc + 1'b1;
    assign uop_addr  = pc;
    assign uop_out   = uop;
    assign uop_valid = issue;
    assign busy      = state == ST_RUN;
    assign fault     = state == ST_FAULT;
    mcseq_stack #(.DEPTH(STACK_DEPTH), .W(ADDR_W)) u_stack (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .top   (top),
        .full  (full),
        .empty (empty)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            pc    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            cnt   <= cnt_n;
        end
    end
    always_comb begin
        state_n = state;
        pc_n    = pc;
        cnt_n   = cnt;
        push    = 1'b0;
        pop     = 1'b0;
        clr     = 1'b0;
        issue   = 1'b0;
        case (state)
            ST_IDLE, ST_FAULT: begin
                if (start) begin
                    pc_n    = entry_addr;
                    state_n = ST_RUN;
                    clr     = state == ST_FAULT;
                end
            end
            ST_RUN: begin
                case (op)
                    OP_JMP:   pc_n = target;
                    OP_BRC:   pc_n = cond[sel] ? target : pc_inc;
                    OP_CALL: begin
                        if (full) begin
                            state_n = ST_FAULT;
                        end else begin
                            push = 1'b1;
                            pc_n = target;
                        end
                    end
                    OP_RET: begin
                        if (empty) begin
                            state_n = ST_FAULT;
                        end else begin
                            pop  = 1'b1;
                            pc_n = top;
                        end
                    end
                    OP_LDCNT: begin
                        cnt_n = imm;
                        pc_n  = pc_inc;
                    end
                    OP_LOOP: begin
                        cnt_n = cnt != '0 ? cnt - 1'b1 : cnt;
                        pc_n  = cnt != '0 ? target : pc_inc;
                    end
                    OP_END:   state_n = ST_IDLE;
                    default: begin
`ifdef MCSEQ_ILLEGAL_TRAP_EN
                        if (is_ext_op(op)) begin
                            state_n = ST_FAULT;
                        end else begin
                            issue = 1'b1;
                            pc_n  = uop_ready ? pc_inc : pc;
                        end
`else
                        issue = 1'b1;
                        pc_n  = uop_ready ? pc_inc : pc;
`endif
                    end
                endcase
            end
            default: state_n = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_microcode_sequencer.sv
// tb_microcode_sequencer: directed programs in a modelled uop store; issued uops checked against a scoreboard.
module tb_microcode_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        uop_ready = 1'b1;
    logic [6:0]  entry_addr = '0;
    logic [6:0]  uop_addr;
    logic [31:0] uop, uop_out;
    logic [7:0]  cond = '0;
    logic        uop_valid, busy, fault;
    logic [31:0] store [0:127];
    logic [38:0] expq [$];
    logic [38:0] e;
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b1;

    always #5 clk = ~clk;
    assign uop = store[uop_addr];

    microcode_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .entry_addr (entry_addr),
        .uop_addr   (uop_addr),
        .uop        (uop),
        .cond       (cond),
        .uop_out    (uop_out),
        .uop_valid  (uop_valid),
        .uop_ready  (uop_ready),
        .busy       (busy),
        .fault      (fault)
    );

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [2:0] sel, input logic [7:0] low);
        return {op, sel, 17'h0, low};
    endfunction

    function automatic logic [31:0] nxt(input logic [6:0] a);
        return {4'h0, 12'hA5A, 9'h0, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_issue(input logic [6:0] a, input logic [31:0] d);
        expq.push_back({a, d});
    endtask

    task automatic start_at(input logic [6:0] a);
        @(posedge clk); #1;
        start = 1'b1;
        entry_addr = a;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        for (int i = 0; i < max && busy; i++) begin
            @(posedge clk); #1;
        end
        chk("wait_idle_busy", 32'(busy), 32'd0);
    endtask

    always @(negedge clk) begin
        if (reset && mon_en && uop_valid && uop_ready) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue: got addr %0h uop %0h, expected no issue", uop_addr, uop_out);
            end else begin
                e = expq.pop_front();
                chk("issue_addr", 32'(uop_addr), 32'(e[38:32]));
                chk("issue_uop", uop_out, e[31:0]);
            end
        end
    end

    initial begin
        for (int i = 0; i < 128; i++) store[i] = mk(4'h7, 3'h0, 8'h0);
        for (int i = 16; i < 19; i++) store[i] = nxt(7'(i));
        store[7'h20] = nxt(7'h20);
        store[7'h05] = mk(4'h2, 3'd3, 8'h40);
        for (int i = 0; i < 5; i++) store[7'h50 + i] = mk(4'h3, 3'h0, 8'(8'h51 + i));
        store[7'h58] = mk(4'h3, 3'h0, 8'h5C);
        store[7'h59] = nxt(7'h59);
        store[7'h5C] = mk(4'h4, 3'h0, 8'h0);
        store[7'h60] = mk(4'h4, 3'h0, 8'h0);
        store[7'h30] = mk(4'h5, 3'h0, 8'h02);
        store[7'h31] = nxt(7'h31);
        store[7'h32] = mk(4'h6, 3'h0, 8'h31);
        store[7'h7F] = nxt(7'h7F);
        store[7'h70] = {4'hC, 28'h0123456};
        store[7'h08] = nxt(7'h08);
        store[7'h09] = mk(4'h1, 3'h0, 8'h08);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_addr", 32'(uop_addr), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_valid", 32'(uop_valid), 32'h0);
        chk("rst_fault", 32'(fault), 32'h0);
        reset = 1'b1;

        for (int i = 16; i < 19; i++) expect_issue(7'(i), nxt(7'(i)));
        start_at(7'h10);
        chk("t1_busy", 32'(busy), 32'h1);
        wait_idle(20);
        chk("t1_end_addr", 32'(uop_addr), 32'h13);

        uop_ready = 1'b0;
        start_at(7'h20);
        for (int i = 0; i < 4; i++) begin
            chk("stall_addr", 32'(uop_addr), 32'h20);
            chk("stall_valid", 32'(uop_valid), 32'h1);
            chk("stall_uop", uop_out, nxt(7'h20));
            @(posedge clk); #1;
        end
        expect_issue(7'h20, nxt(7'h20));
        uop_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_release_addr", 32'(uop_addr), 32'h21);
        wait_idle(20);

        cond = 8'h08;
        start_at(7'h05);
        @(posedge clk); #1;
        chk("brc_taken", 32'(uop_addr), 32'h40);
        wait_idle(20);
        cond = 8'h00;
        start_at(7'h05);
        @(posedge clk); #1;
        chk("brc_not_taken", 32'(uop_addr), 32'h06);
        wait_idle(20);

        expect_issue(7'h59, nxt(7'h59));
        start_at(7'h58);
        wait_idle(20);
        chk("callret_addr", 32'(uop_addr), 32'h5A);
        chk("callret_fault", 32'(fault), 32'h0);

        start_at(7'h50);
        repeat (4) begin
            chk("call_ok_busy", 32'(busy), 32'h1);
            @(posedge clk); #1;
        end
        chk("call_addr_5th", 32'(uop_addr), 32'h54);
        wait_idle(20);
        chk("call_overflow_fault", 32'(fault), 32'h1);
        chk("call_overflow_valid", 32'(uop_valid), 32'h0);
        start_at(7'h60);
        wait_idle(20);
        chk("ret_underflow_fault", 32'(fault), 32'h1);
        start_at(7'h13);
        chk("start_clears_fault", 32'(fault), 32'h0);
        wait_idle(20);

        for (int i = 0; i < 3; i++) expect_issue(7'h31, nxt(7'h31));
        start_at(7'h30);
        wait_idle(40);
        chk("loop_end_addr", 32'(uop_addr), 32'h33);
        chk("loop_issue_count", expq.size(), 32'd0);

        expect_issue(7'h7F, nxt(7'h7F));
        start_at(7'h7F);
        wait_idle(20);
        chk("wrap_addr", 32'(uop_addr), 32'h00);
        chk("wrap_fault", 32'(fault), 32'h0);

`ifdef MCSEQ_ILLEGAL_TRAP_EN
        start_at(7'h70);
        wait_idle(20);
        chk("op_c_trap_fault", 32'(fault), 32'h1);
        chk("op_c_trap_addr", 32'(uop_addr), 32'h70);
        start_at(7'h13);
        wait_idle(20);
`else
        expect_issue(7'h70, {4'hC, 28'h0123456});
        start_at(7'h70);
        wait_idle(20);
        chk("op_c_fault", 32'(fault), 32'h0);
        chk("op_c_addr", 32'(uop_addr), 32'h71);
`endif

        mon_en = 1'b0;
        start_at(7'h08);
        repeat (5) @(posedge clk);
        #1;
        chk("midrun_busy", 32'(busy), 32'h1);
        reset = 1'b0;
        #1;
        chk("async_rst_addr", 32'(uop_addr), 32'h0);
        chk("async_rst_busy", 32'(busy), 32'h0);
        chk("async_rst_valid", 32'(uop_valid), 32'h0);
        @(posedge clk); #1;
        chk("rst_hold_valid", 32'(uop_valid), 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("after_rst_busy", 32'(busy), 32'h0);
        mon_en = 1'b1;

        chk("queue_empty", expq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
